// File: rtl/snn_spike_flatten.sv
// snn_spike_flatten: turns pooled spikes {ch, y, x, valid} into flat FC neuron indices.
// A decode register feeds an output FIFO whose head slot is the registered output beat.
// Optional macro SNN_FLATTEN_DEDUP_EN: forward at most one spike per neuron per timestep.
module snn_spike_flatten #(
  parameter int unsigned IN_HEIGHT   = 4,
  parameter int unsigned IN_WIDTH    = 4,
  parameter int unsigned IN_CHANNELS = 4,
  parameter int unsigned INDEX_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] s_axis_input_tdata,
  input  logic        s_axis_input_tvalid,
  output logic        s_axis_input_tready,
  input  logic        s_axis_input_tlast,
  output logic [31:0] m_axis_output_tdata,
  output logic        m_axis_output_tvalid,
  input  logic        m_axis_output_tready,
  output logic        m_axis_output_tlast,
  output logic [31:0] input_spike_count,
  output logic [31:0] output_spike_count,
  output logic [31:0] dropped_count
);

  localparam int unsigned PLANE   = IN_HEIGHT * IN_WIDTH;
  localparam int unsigned NEURONS = IN_CHANNELS * PLANE;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam int unsigned ENTRY_W = INDEX_WIDTH + 2;

  logic [7:0]             in_ch, in_y, in_x;
  logic                   in_range_c, keep_c, accept_c;
  logic [INDEX_WIDTH-1:0] raw_index_c;
  logic [CW:0]            occ_c;

  logic                   dec_valid, dec_keep, dec_last;
  logic [INDEX_WIDTH-1:0] dec_index;

  logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          mem_count;
  logic [ENTRY_W-1:0]     head_c;
  logic                   head_last_c, head_keep_c, head_emit_c;
  logic [INDEX_WIDTH-1:0] head_index_c;
  logic                   slot_free_c, pop_c, out_pop_c;
  logic                   unused_valid_bits;

  assign in_ch = s_axis_input_tdata[31:24];
  assign in_y  = s_axis_input_tdata[23:16];
  assign in_x  = s_axis_input_tdata[15:8];
  assign unused_valid_bits = ^s_axis_input_tdata[7:1];

  // Input is ready while the decode stage plus buffered beats leave room for one more
  assign occ_c = (CW+1)'(mem_count) + (CW+1)'(m_axis_output_tvalid) + (CW+1)'(dec_valid);
  assign s_axis_input_tready = reset && enable && (occ_c < (CW+1)'(FIFO_DEPTH));
  assign accept_c = s_axis_input_tvalid && s_axis_input_tready;

  // Range check and flat index arithmetic for the incoming beat
  always_comb begin
    in_range_c  = s_axis_input_tdata[0]
                  && (32'(in_ch) < IN_CHANNELS)
                  && (32'(in_y) < IN_HEIGHT)
                  && (32'(in_x) < IN_WIDTH);
    raw_index_c = INDEX_WIDTH'(in_ch) * INDEX_WIDTH'(PLANE)
                + INDEX_WIDTH'(in_y) * INDEX_WIDTH'(IN_WIDTH)
                + INDEX_WIDTH'(in_x);
  end

`ifdef SNN_FLATTEN_DEDUP_EN
  localparam int unsigned NB = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  logic [NEURONS-1:0] seen;

  assign keep_c = in_range_c && !seen[NB'(raw_index_c)];

  // Per-timestep neuron bitmap; an accepted tlast beat is checked first, then clears it
  always_ff @(posedge clk) begin
    if (!reset) begin
      seen <= '0;
    end else if (accept_c) begin
      if (s_axis_input_tlast) seen <= '0;
      else if (keep_c)        seen[NB'(raw_index_c)] <= 1'b1;
    end
  end
`else
  assign keep_c = in_range_c;
`endif

  // Stage 1 decode register, committed to the FIFO on the following cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      dec_valid <= 1'b0;
      dec_keep  <= 1'b0;
      dec_last  <= 1'b0;
      dec_index <= '0;
    end else begin
      dec_valid <= accept_c;
      if (accept_c) begin
        dec_keep  <= keep_c;
        dec_last  <= s_axis_input_tlast;
        dec_index <= keep_c ? raw_index_c : '0;
      end
    end
  end

  // FIFO head classification and pop conditions
  always_comb begin
    head_c       = mem[rd_ptr];
    head_last_c  = head_c[ENTRY_W-1];
    head_keep_c  = head_c[ENTRY_W-2];
    head_index_c = head_c[INDEX_WIDTH-1:0];
    head_emit_c  = head_keep_c || head_last_c;
    slot_free_c  = !m_axis_output_tvalid || m_axis_output_tready;
    pop_c        = slot_free_c && (mem_count != '0);
    out_pop_c    = m_axis_output_tvalid && m_axis_output_tready;
  end

  // FIFO storage, no reset needed since occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (dec_valid) mem[wr_ptr] <= {dec_last, dec_keep, dec_index};
  end

  // FIFO pointers, registered output slot and statistics counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      mem_count            <= '0;
      m_axis_output_tvalid <= 1'b0;
      m_axis_output_tdata  <= '0;
      m_axis_output_tlast  <= 1'b0;
      input_spike_count    <= '0;
      output_spike_count   <= '0;
      dropped_count        <= '0;
    end else begin
      if (dec_valid) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
      mem_count <= mem_count + CW'(dec_valid) - CW'(pop_c);
      if (slot_free_c) begin
        m_axis_output_tvalid <= pop_c && head_emit_c;
        if (pop_c && head_emit_c) begin
          m_axis_output_tdata <= {~head_keep_c, 15'b0, head_keep_c ? 16'(head_index_c) : 16'd0};
          m_axis_output_tlast <= head_last_c;
        end
      end
      if (accept_c)                                  input_spike_count  <= input_spike_count + 32'd1;
      if (out_pop_c && !m_axis_output_tdata[31])     output_spike_count <= output_spike_count + 32'd1;
      if (pop_c && !head_keep_c)                     dropped_count      <= dropped_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_snn_spike_flatten.sv
// Self-checking bench for snn_spike_flatten: spec-level model of expected beats and counters.
module tb_snn_spike_flatten;

  localparam int H = 4, W = 4, C = 4, N = C * H * W;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_ready = 1'b0;
  logic [31:0] in_cnt, out_cnt, drop_cnt;

  snn_spike_flatten dut (
    .clk(clk), .reset(reset), .enable(enable),
    .s_axis_input_tdata(s_tdata), .s_axis_input_tvalid(s_tvalid),
    .s_axis_input_tready(s_tready), .s_axis_input_tlast(s_tlast),
    .m_axis_output_tdata(m_tdata), .m_axis_output_tvalid(m_tvalid),
    .m_axis_output_tready(m_ready), .m_axis_output_tlast(m_tlast),
    .input_spike_count(in_cnt), .output_spike_count(out_cnt), .dropped_count(drop_cnt)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0, errors = 0;
  logic [32:0] exp_q[$];            // {tlast, tdata}
  bit          seen[N];
  int unsigned m_in = 0, m_out = 0, m_drop = 0, rx_nulls = 0;
  bit          acc = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int ch, input int y, input int x, input logic [7:0] v);
    return {8'(ch), 8'(y), 8'(x), v};
  endfunction

  // Spec-level model of one accepted beat
  task automatic model_accept(input logic [31:0] d, input logic last);
    int ch, y, x, idx;
    bit keep;
    ch = int'(d[31:24]); y = int'(d[23:16]); x = int'(d[15:8]);
    keep = d[0] && ch < C && y < H && x < W;
    idx  = keep ? ch * H * W + y * W + x : 0;
`ifdef SNN_FLATTEN_DEDUP_EN
    if (keep) begin
      if (seen[idx]) keep = 1'b0;
      else seen[idx] = 1'b1;
    end
    if (last) foreach (seen[i]) seen[i] = 1'b0;
`endif
    m_in++;
    if (keep) exp_q.push_back({last, 32'(idx)});
    else begin
      m_drop++;
      if (last) exp_q.push_back({1'b1, 32'h8000_0000});
    end
  endtask

  function automatic void model_clear();
    exp_q.delete();
    foreach (seen[i]) seen[i] = 1'b0;
    m_in = 0; m_out = 0; m_drop = 0; rx_nulls = 0;
  endfunction

  // One clock: compare at the falling edge, return 1 time unit after the rising edge
  task automatic step();
    logic [32:0] e;
    @(negedge clk);
    acc = 1'b0;
    if (reset) begin
      if (!enable && s_tready) chk("tready_when_disabled", 32'(s_tready), 32'd0);
      if (prev_hold) begin
        chk("hold_valid", 32'(m_tvalid), 32'd1);
        chk("hold_data", m_tdata, prev_data);
        chk("hold_last", 32'(m_tlast), 32'(prev_last));
      end
      if (m_tvalid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_beat unexpected got=0x%08h last=%0b", m_tdata, m_tlast);
        end else begin
          e = exp_q.pop_front();
          chk("out_tdata", m_tdata, e[31:0]);
          chk("out_tlast", 32'(m_tlast), 32'(e[32]));
          if (!e[31]) m_out++;
          if (m_tdata[31]) rx_nulls++;
        end
      end
      if (s_tvalid && s_tready) begin
        acc = 1'b1;
        model_accept(s_tdata, s_tlast);
      end
      prev_hold = m_tvalid && !m_ready;
      prev_data = m_tdata;
      prev_last = m_tlast;
    end else prev_hold = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; s_tvalid = 1'b0;
    repeat (2) step();
    model_clear();
    reset = 1'b1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    do begin
      step();
      n++;
    end while (!acc && n < 500);
    if (!acc) begin checks++; errors++; $display("FAIL send_timeout got=0 exp=1"); end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic drain();
    s_tvalid = 1'b0; m_ready = 1'b1; enable = 1'b1;
    repeat (60) step();
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_tvalid_low", 32'(m_tvalid), 32'd0);
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_in_cnt"}, in_cnt, m_in);
    chk({tag, "_out_cnt"}, out_cnt, m_out);
    chk({tag, "_drop_cnt"}, drop_cnt, m_drop);
  endtask

  initial begin
    int acc_n;
    logic [7:0] vb;
    // Reset state, with enable high so tready must still be held low
    enable = 1'b1; m_ready = 1'b1;
    repeat (3) step();
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_in_cnt", in_cnt, 32'd0);
    chk("rst_out_cnt", out_cnt, 32'd0);
    chk("rst_drop_cnt", drop_cnt, 32'd0);
    model_clear();
    reset = 1'b1;

    // Single spike (1,2,3): index 27, tvalid two edges after acceptance
    send(pack(1, 2, 3, 8'h01), 1'b0);
    chk("t1_model_index", exp_q[0][31:0], 32'd27);
    chk("t1_lat_edge1", 32'(m_tvalid), 32'd0);
    step();
    chk("t1_lat_edge2", 32'(m_tvalid), 32'd0);
    step();
    chk("t1_lat_valid", 32'(m_tvalid), 32'd1);
    chk("t1_lat_data", m_tdata, 32'd27);
    drain();
    chk("t1_out_cnt_lit", out_cnt, 32'd1);
    check_counters("t1");

    // Out-of-range y and cleared valid bit: both dropped silently
    do_reset();
    send(pack(0, 4, 0, 8'h01), 1'b0);
    send(pack(0, 0, 0, 8'h00), 1'b0);
    drain();
    chk("t2_drop_lit", drop_cnt, 32'd2);
    chk("t2_in_lit", in_cnt, 32'd2);
    check_counters("t2");

    // Out-of-range channel with tlast: one null beat
    do_reset();
    send(pack(5, 0, 0, 8'h01), 1'b1);
    chk("t3_model_null", exp_q[0][31:0], 32'h8000_0000);
    drain();
    chk("t3_nulls_lit", 32'(rx_nulls), 32'd1);
    chk("t3_drop_lit", drop_cnt, 32'd1);
    check_counters("t3");

    // Backpressure: 16 beats fill the block, the rest wait without loss
    do_reset();
    m_ready = 1'b0; acc_n = 0;
    for (int c = 0; c < 40; c++) begin
      s_tvalid = (acc_n < 20);
      s_tdata = pack(acc_n / 16, (acc_n / 4) % 4, acc_n % 4, 8'h01);
      step();
      if (acc) acc_n++;
    end
    chk("t4_accepted_full", 32'(acc_n), 32'd16);
    chk("t4_tready_full", 32'(s_tready), 32'd0);
    m_ready = 1'b1;
    for (int c = 0; c < 100 && acc_n < 20; c++) begin
      s_tvalid = 1'b1;
      s_tdata = pack(acc_n / 16, (acc_n / 4) % 4, acc_n % 4, 8'h01);
      step();
      if (acc) acc_n++;
    end
    chk("t4_accepted_all", 32'(acc_n), 32'd20);
    drain();
    chk("t4_out_lit", out_cnt, 32'd20);
    check_counters("t4");

    // Full sweep, tlast on the final neuron only
    do_reset();
    s_tvalid = 1'b1;
    acc_n = 0;
    for (int c = 0; c < 300 && acc_n < 64; c++) begin
      s_tdata = pack(acc_n / 16, (acc_n / 4) % 4, acc_n % 4, 8'h01);
      s_tlast = (acc_n == 63);
      step();
      if (acc) acc_n++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    drain();
    chk("t5_out_lit", out_cnt, 32'd64);
    check_counters("t5");

    // Repeated neuron across a timestep boundary
    do_reset();
    send(pack(0, 0, 1, 8'h01), 1'b0);
    send(pack(0, 0, 1, 8'h01), 1'b0);
    send(pack(0, 0, 1, 8'h01), 1'b1);
    send(pack(0, 0, 1, 8'h01), 1'b0);
    drain();
`ifdef SNN_FLATTEN_DEDUP_EN
    chk("t6_out_lit", out_cnt, 32'd2);
    chk("t6_drop_lit", drop_cnt, 32'd2);
    chk("t6_nulls_lit", 32'(rx_nulls), 32'd1);
`else
    chk("t6_out_lit", out_cnt, 32'd4);
    chk("t6_drop_lit", drop_cnt, 32'd0);
    chk("t6_nulls_lit", 32'(rx_nulls), 32'd0);
`endif
    check_counters("t6");

    // Randomized traffic with random enable and downstream backpressure
    do_reset();
    acc = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!s_tvalid || acc) begin
        if ($urandom_range(3) != 0) begin
          vb = 8'($urandom_range(255));
          if ($urandom_range(7) != 0) vb[0] = 1'b1;
          s_tdata  = pack($urandom_range(4), $urandom_range(4), $urandom_range(4), vb);
          s_tlast  = ($urandom_range(7) == 0);
          s_tvalid = 1'b1;
        end else begin
          s_tvalid = 1'b0; s_tlast = 1'b0;
        end
      end
      enable  = ($urandom_range(7) != 0);
      m_ready = ($urandom_range(3) != 0);
      step();
    end
    drain();
    check_counters("t7");

    // Reset in the middle of buffered traffic discards everything
    m_ready = 1'b0;
    for (int c = 0; c < 25; c++) begin
      s_tvalid = 1'b1;
      s_tdata = pack(c % 4, (c / 4) % 4, 1, 8'h01);
      step();
    end
    do_reset();
    chk("t8_tvalid_after_rst", 32'(m_tvalid), 32'd0);
    chk("t8_tdata_after_rst", m_tdata, 32'd0);
    check_counters("t8_rst");
    m_ready = 1'b1;
    repeat (10) step();
    send(pack(3, 3, 3, 8'h01), 1'b1);
    drain();
    chk("t8_out_lit", out_cnt, 32'd1);
    check_counters("t8");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
